// File: rtl/round_controller_pkg.sv
//==============================================================================
// Module   : round_controller_pkg
// Brief    : Shared encodings and default timing for the best-of-N round sequencer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package round_controller_pkg;

    typedef enum logic [1:0] {
        PH_FIGHT      = 2'b00,
        PH_ROUND_END  = 2'b01,
        PH_MATCH_OVER = 2'b10,
        PH_RESETTING  = 2'b11
    } phase_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam int DEF_ROUNDS_TO_WIN      = 2;
    localparam int DEF_HOLD_TICKS         = 40;
    localparam int DEF_INTERMISSION_TICKS = 60;
    localparam int DEF_RESET_TICKS        = 2;

    localparam int HOLD_CNT_W = 6;
    localparam int CD_W       = 7;

    function automatic logic [1:0] sat_inc(input logic [1:0] v, input logic [1:0] lim);
        return (v >= lim) ? lim : v + 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/round_controller_hold.sv
//==============================================================================
// Module   : hold_detector
// Brief    : 2-flop synchronizer plus tick-gated saturating hold counter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module hold_detector
    import round_controller_pkg::*;
#(
    parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic en,
    input  logic btn,
    output logic done
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_TICKS - 1);

    logic [1:0]            sync_q, sync_d;
    logic [HOLD_CNT_W-1:0] cnt_q, cnt_d;

    // done fires only on the tick that moves the count onto HOLD_TICKS, so a
    // saturated counter under a still-held button never fires again.
    always_comb begin
        sync_d = {sync_q[0], btn};
        cnt_d  = cnt_q;
        done   = 1'b0;
        if (tick) begin
            if (en && sync_q[1]) begin
                if (cnt_q == HOLD_LAST) begin
                    done = 1'b1;
                end
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/round_controller.sv
//==============================================================================
// Module   : round_controller
// Brief    : Best-of-N match sequencer driving the per-round reset and scores.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module round_controller
    import round_controller_pkg::*;
#(
    parameter int ROUNDS_TO_WIN      = DEF_ROUNDS_TO_WIN,
    parameter int HOLD_TICKS         = DEF_HOLD_TICKS,
    parameter int INTERMISSION_TICKS = DEF_INTERMISSION_TICKS,
    parameter int RESET_TICKS        = DEF_RESET_TICKS
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            tick,
    input  logic [1:0]      winner,
    input  logic            confirm_btn,
    input  logic            force_reset,
    output logic            round_reset,
    output logic [1:0]      p1_rounds,
    output logic [1:0]      p2_rounds,
    output logic [1:0]      phase,
    output logic [1:0]      match_winner,
    output logic [CD_W-1:0] countdown
);

    localparam logic [1:0]      SCORE_WIN = 2'(ROUNDS_TO_WIN);
    localparam logic [CD_W-1:0] CD_LOAD   = CD_W'(INTERMISSION_TICKS);
    localparam logic [3:0]      RST_LAST  = 4'(RESET_TICKS - 1);

    phase_t          state_q, state_d;
    logic            round_reset_q, round_reset_d;
    logic [1:0]      p1_q, p1_d;
    logic [1:0]      p2_q, p2_d;
    logic [1:0]      match_winner_q, match_winner_d;
    logic [CD_W-1:0] countdown_q, countdown_d;
    logic            armed_q, armed_d;
    logic            clear_scores_q, clear_scores_d;
    logic [3:0]      reset_cnt_q, reset_cnt_d;
    logic [1:0]      new_p1, new_p2;
    logic            confirm_done, force_done;

    hold_detector #(.HOLD_TICKS(HOLD_TICKS)) u_confirm_hold (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .en      (state_q == PH_MATCH_OVER),
        .btn     (confirm_btn),
        .done    (confirm_done)
    );

    hold_detector #(.HOLD_TICKS(HOLD_TICKS)) u_force_hold (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .en      (1'b1),
        .btn     (force_reset),
        .done    (force_done)
    );

    always_comb begin
        state_d        = state_q;
        round_reset_d  = round_reset_q;
        p1_d           = p1_q;
        p2_d           = p2_q;
        match_winner_d = match_winner_q;
        countdown_d    = countdown_q;
        armed_d        = armed_q;
        clear_scores_d = clear_scores_q;
        reset_cnt_d    = reset_cnt_q;
        new_p1         = (winner == WIN_P1) ? sat_inc(p1_q, SCORE_WIN) : p1_q;
        new_p2         = (winner == WIN_P2) ? sat_inc(p2_q, SCORE_WIN) : p2_q;

        if (tick) begin
            // A completed force hold overrides whatever the state would do,
            // including a result arriving on the same tick.
            if (force_done) begin
                state_d        = PH_RESETTING;
                round_reset_d  = 1'b1;
                reset_cnt_d    = '0;
                clear_scores_d = 1'b1;
                countdown_d    = '0;
            end else begin
                case (state_q)
                    PH_RESETTING: begin
                        if (reset_cnt_q == RST_LAST) begin
                            state_d       = PH_FIGHT;
                            round_reset_d = 1'b0;
                            armed_d       = 1'b0;
                            reset_cnt_d   = '0;
                            if (clear_scores_q) begin
                                p1_d           = '0;
                                p2_d           = '0;
                                match_winner_d = WIN_NONE;
                                clear_scores_d = 1'b0;
                            end
                        end else begin
                            reset_cnt_d = reset_cnt_q + 4'd1;
                        end
                    end
                    PH_FIGHT: begin
                        if (!armed_q) begin
                            if (winner == WIN_NONE) begin
                                armed_d = 1'b1;
                            end
                        end else if (winner != WIN_NONE) begin
                            p1_d = new_p1;
                            p2_d = new_p2;
                            if ((winner == WIN_P1) && (new_p1 == SCORE_WIN)) begin
                                state_d        = PH_MATCH_OVER;
                                match_winner_d = WIN_P1;
                            end else if ((winner == WIN_P2) && (new_p2 == SCORE_WIN)) begin
                                state_d        = PH_MATCH_OVER;
                                match_winner_d = WIN_P2;
                            end else begin
                                state_d     = PH_ROUND_END;
                                countdown_d = CD_LOAD;
                            end
                        end
                    end
                    PH_ROUND_END: begin
                        if (countdown_q <= CD_W'(1)) begin
                            countdown_d    = '0;
                            state_d        = PH_RESETTING;
                            round_reset_d  = 1'b1;
                            reset_cnt_d    = '0;
                            clear_scores_d = 1'b0;
                        end else begin
                            countdown_d = countdown_q - 1'b1;
                        end
                    end
                    PH_MATCH_OVER: begin
                        if (confirm_done) begin
                            state_d        = PH_RESETTING;
                            round_reset_d  = 1'b1;
                            reset_cnt_d    = '0;
                            clear_scores_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d = PH_RESETTING;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= PH_RESETTING;
            round_reset_q  <= 1'b1;
            p1_q           <= '0;
            p2_q           <= '0;
            match_winner_q <= WIN_NONE;
            countdown_q    <= '0;
            armed_q        <= 1'b0;
            clear_scores_q <= 1'b0;
            reset_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            round_reset_q  <= round_reset_d;
            p1_q           <= p1_d;
            p2_q           <= p2_d;
            match_winner_q <= match_winner_d;
            countdown_q    <= countdown_d;
            armed_q        <= armed_d;
            clear_scores_q <= clear_scores_d;
            reset_cnt_q    <= reset_cnt_d;
        end
    end

    assign round_reset  = round_reset_q;
    assign p1_rounds    = p1_q;
    assign p2_rounds    = p2_q;
    assign phase        = state_q;
    assign match_winner = match_winner_q;
    assign countdown    = countdown_q;

endmodule

`default_nettype wire

// File: tb/tb_round_controller.sv
//==============================================================================
// Module   : tb_round_controller
// Brief    : Scenario bench for round_controller against a tick-level match model.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_round_controller;

    localparam int HOLD  = 40;
    localparam int INTER = 60;
    localparam int RST   = 2;
    localparam int WINS  = 2;

    localparam int M_FIGHT = 0;
    localparam int M_END   = 1;
    localparam int M_OVER  = 2;
    localparam int M_RESET = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] winner = 2'b00;
    logic       confirm_btn = 1'b0;
    logic       force_reset = 1'b0;
    logic       round_reset;
    logic [1:0] p1_rounds, p2_rounds, phase, match_winner;
    logic [6:0] countdown;

    int checks = 0;
    int errors = 0;

    // Match model, one update per game tick
    int m_phase, m_p1, m_p2, m_mw, m_cd, m_rst_left, m_conf, m_force;
    bit m_armed, m_clear;

    always #5 clk = ~clk;

    round_controller #(
        .ROUNDS_TO_WIN      (WINS),
        .HOLD_TICKS         (HOLD),
        .INTERMISSION_TICKS (INTER),
        .RESET_TICKS        (RST)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick         (tick),
        .winner       (winner),
        .confirm_btn  (confirm_btn),
        .force_reset  (force_reset),
        .round_reset  (round_reset),
        .p1_rounds    (p1_rounds),
        .p2_rounds    (p2_rounds),
        .phase        (phase),
        .match_winner (match_winner),
        .countdown    (countdown)
    );

    task automatic model_reset();
        m_phase = M_RESET; m_rst_left = RST; m_clear = 0; m_armed = 0;
        m_p1 = 0; m_p2 = 0; m_mw = 0; m_cd = 0; m_conf = 0; m_force = 0;
    endtask

    task automatic enter_reset(input bit clr);
        m_phase = M_RESET; m_rst_left = RST; m_clear = clr;
    endtask

    task automatic model_tick(input int w, input bit c, input bit f);
        bit ffire, cfire;
        m_force = f ? ((m_force < 63) ? m_force + 1 : 63) : 0;
        ffire = f && (m_force == HOLD);
        if (m_phase == M_OVER && c) m_conf = (m_conf < 63) ? m_conf + 1 : 63;
        else m_conf = 0;
        cfire = (m_phase == M_OVER) && c && (m_conf == HOLD);
        if (ffire) begin
            enter_reset(1); m_cd = 0;
        end else begin
            case (m_phase)
                M_RESET: begin
                    m_rst_left--;
                    if (m_rst_left == 0) begin
                        m_phase = M_FIGHT; m_armed = 0;
                        if (m_clear) begin m_p1 = 0; m_p2 = 0; m_mw = 0; m_clear = 0; end
                    end
                end
                M_FIGHT: begin
                    if (!m_armed) begin
                        if (w == 0) m_armed = 1;
                    end else if (w != 0) begin
                        if (w == 1) m_p1 = (m_p1 < WINS) ? m_p1 + 1 : WINS;
                        if (w == 2) m_p2 = (m_p2 < WINS) ? m_p2 + 1 : WINS;
                        if (w == 1 && m_p1 == WINS) begin m_phase = M_OVER; m_mw = 1; end
                        else if (w == 2 && m_p2 == WINS) begin m_phase = M_OVER; m_mw = 2; end
                        else begin m_phase = M_END; m_cd = INTER; end
                    end
                end
                M_END: begin
                    m_cd--;
                    if (m_cd == 0) enter_reset(0);
                end
                default: begin
                    if (cfire) enter_reset(1);
                end
            endcase
        end
    endtask

    function automatic logic [15:0] exp_vec();
        return {(m_phase == M_RESET), 2'(m_phase), 2'(m_p1), 2'(m_p2), 2'(m_mw), 7'(m_cd)};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {round_reset, phase, p1_rounds, p2_rounds, match_winner, countdown};
    endfunction

    // Inputs change at a negedge, settle through the synchronizer, then one tick fires
    task automatic step(input logic [1:0] w, input logic c, input logic f);
        @(negedge clk);
        winner = w; confirm_btn = c; force_reset = f;
        repeat (2) @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        model_tick(int'(w), c, f);
    endtask

    task automatic reach_match_over(input logic [1:0] w);
        for (int i = 0; i < 400 && m_phase != M_OVER; i++) begin
            if (m_phase == M_FIGHT && m_armed) step(w, 1'b0, 1'b0);
            else step(2'b00, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec() !== exp_vec() || round_reset !== 1'b1) begin
            errors++; $display("FAIL reset_state: got %h expected %h", dut_vec(), exp_vec());
        end
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < RST; i++) begin
            step(2'b00, 1'b0, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL reset_release tick %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if ({round_reset, phase, p1_rounds, p2_rounds} !== 7'b0_00_00_00) begin
            errors++; $display("FAIL reset_to_fight: got %b expected 0000000", {round_reset, phase, p1_rounds, p2_rounds});
        end
    endtask

    task automatic test_p1_round();
        step(2'b00, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        checks++;
        if (p1_rounds !== 2'd1 || phase !== 2'b01 || countdown !== 7'd60) begin
            errors++; $display("FAIL p1_result: got p1=%0d ph=%b cd=%0d expected p1=1 ph=01 cd=60", p1_rounds, phase, countdown);
        end
        for (int i = 0; i < INTER + RST + 5; i++) begin
            step(2'b01, 1'b0, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL p1_intermission tick %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (phase !== 2'b00 || p1_rounds !== 2'd1) begin
            errors++; $display("FAIL p1_stale: got ph=%b p1=%0d expected ph=00 p1=1", phase, p1_rounds);
        end
        step(2'b00, 1'b0, 1'b0);
    endtask

    task automatic test_draw();
        step(2'b11, 1'b0, 1'b0);
        checks++;
        if (phase !== 2'b01 || p1_rounds !== 2'd1 || p2_rounds !== 2'd0) begin
            errors++; $display("FAIL draw: got ph=%b p1=%0d p2=%0d expected ph=01 p1=1 p2=0", phase, p1_rounds, p2_rounds);
        end
    endtask

    task automatic test_force_round_end();
        for (int i = 0; i < HOLD + 5; i++) begin
            if (i < 5) step(2'b11, 1'b0, 1'b0);
            else if (i < HOLD + 4) step(2'b00, 1'b0, 1'b1);
            else step(2'b01, 1'b0, 1'b1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL force_round_end tick %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (phase !== 2'b11 || countdown !== 7'd0 || round_reset !== 1'b1) begin
            errors++; $display("FAIL force_enter: got ph=%b cd=%0d rr=%b expected ph=11 cd=0 rr=1", phase, countdown, round_reset);
        end
        for (int i = 0; i < RST; i++) step(2'b00, 1'b0, 1'b1);
        checks++;
        if (phase !== 2'b00 || p1_rounds !== 2'd0 || p2_rounds !== 2'd0) begin
            errors++; $display("FAIL force_clear: got ph=%b p1=%0d p2=%0d expected ph=00 p1=0 p2=0", phase, p1_rounds, p2_rounds);
        end
        step(2'b00, 1'b0, 1'b0);
    endtask

    task automatic test_force_vs_result();
        for (int i = 0; i < HOLD - 1; i++) step(2'b00, 1'b0, 1'b1);
        step(2'b10, 1'b0, 1'b1);
        checks++;
        if (phase !== 2'b11 || p2_rounds !== 2'd0 || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL force_drops_result: got %h expected %h", dut_vec(), exp_vec());
        end
        for (int i = 0; i < RST + 1; i++) begin
            step(2'b00, 1'b0, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL force_recover tick %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_p2_match();
        reach_match_over(2'b10);
        checks++;
        if (phase !== 2'b10 || match_winner !== 2'b10 || p2_rounds !== 2'd2) begin
            errors++; $display("FAIL p2_match: got ph=%b mw=%b p2=%0d expected ph=10 mw=10 p2=2", phase, match_winner, p2_rounds);
        end
        for (int i = 0; i < HOLD - 1; i++) step(2'b00, 1'b1, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        checks++;
        if (phase !== 2'b10 || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL confirm_short: got %h expected %h", dut_vec(), exp_vec());
        end
        for (int i = 0; i < HOLD + RST; i++) begin
            step(2'b00, 1'b1, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL confirm_hold tick %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if ({phase, p1_rounds, p2_rounds, match_winner} !== 8'h00) begin
            errors++; $display("FAIL confirm_clear: got %h expected 00", {phase, p1_rounds, p2_rounds, match_winner});
        end
    endtask

    task automatic test_async_reset();
        reach_match_over(2'b01);
        for (int i = 0; i < 10; i++) step(2'b00, 1'b1, 1'b0);
        @(posedge clk);
        #3 reset_n = 1'b0;
        confirm_btn = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_vec() !== exp_vec() || round_reset !== 1'b1 || phase !== 2'b11) begin
            errors++; $display("FAIL async_reset: got %h expected %h", dut_vec(), exp_vec());
        end
        #3 reset_n = 1'b1;
        for (int i = 0; i < RST; i++) begin
            step(2'b00, 1'b0, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL async_release tick %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_simultaneous();
        reach_match_over(2'b10);
        for (int i = 0; i < HOLD; i++) step(2'b00, 1'b1, 1'b1);
        checks++;
        if (phase !== 2'b11 || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL simul_enter: got %h expected %h", dut_vec(), exp_vec());
        end
        for (int i = 0; i < RST; i++) step(2'b00, 1'b1, 1'b1);
        checks++;
        if (phase !== 2'b00 || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL simul_single_entry: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int cburst = 0;
        int fburst = 0;
        logic [1:0] w;
        logic c, f;
        for (int i = 0; i < 400; i++) begin
            w = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
            if (cburst > 0) begin c = 1'b1; cburst--; end
            else begin c = 1'b0; if ($urandom_range(0, 19) == 0) cburst = $urandom_range(20, 45); end
            if (fburst > 0) begin f = 1'b1; fburst--; end
            else begin f = 1'b0; if ($urandom_range(0, 79) == 0) fburst = $urandom_range(30, 45); end
            step(w, c, f);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL random tick %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_p1_round();
        test_draw();
        test_force_round_end();
        test_force_vs_result();
        test_p2_match();
        test_async_reset();
        test_simultaneous();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
